// File: rtl/bs_pkg.sv
// Shared definitions for the boundary-scan chain.
// This package holds the cell-type encoding used to build CTRL_MASK and the
// counter-width helper.
package bs_pkg;

   // Cell type encoding: one bit per cell in CTRL_MASK.
   typedef enum logic {
      BS_OBSERVE = 1'b0,
      BS_CONTROL = 1'b1
   } bs_cell_e;

   // Width of a counter that must hold the values 0..n inclusive.
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage : bs_pkg

// File: rtl/bs_chain_cell.sv
// One boundary-scan cell.
// It holds one shift bit and one update bit, and drives the pad-side output
// mux. The shift bit has priority over capture. The update bit loads the
// shift bit as it was before any same-cycle shift or capture.
module bs_chain_cell
   import bs_pkg::*;
#(
   parameter bit CONTROLLABLE = BS_CONTROL,
   parameter bit RESET_BIT    = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic shift_en,
   input  logic capture_en,
   input  logic update_en,
   input  logic scan_in,
   input  logic core_in,
   input  logic mode,
   output logic sr,
   output logic pad_out
);

   logic ur;

   // Shift stage: serial shift wins over parallel capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr <= 1'b0;
      end else if (shift_en) begin
         sr <= scan_in;
      end else if (capture_en) begin
         sr <= core_in;
      end
   end

   // Update stage: latches the pre-edge shift bit. It loads even on
   // observe-only cells, where the value is simply never used.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ur <= RESET_BIT;
      end else if (update_en) begin
         ur <= sr;
      end
   end

   // Pad mux: only a controllable cell in test mode overrides the core value.
   always_comb begin
      pad_out = core_in;
      if (mode && CONTROLLABLE) begin
         pad_out = ur;
      end
   end

endmodule : bs_chain_cell

// File: rtl/bs_chain.sv
// N-cell boundary-scan data register that sits between the core and the pads.
// TDI enters at cell N-1 and TDO leaves from cell 0, so the LSB exits first.
// All DR strobes are ignored unless enable_i is high. shift_cnt_o is a
// saturating count of shifts since the last capture.
module bs_chain
   import bs_pkg::*;
#(
   parameter int           N         = 8,
   parameter logic [N-1:0] CTRL_MASK = {N{1'b1}},
   parameter logic [N-1:0] RESET_VAL = {N{1'b0}}
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        enable_i,
   input  logic                        mode_i,
   input  logic                        shift_dr_i,
   input  logic                        capture_dr_i,
   input  logic                        update_dr_i,
   input  logic                        scan_in_i,
   output logic                        scan_out_o,
   input  logic [N-1:0]                core_in_i,
   output logic [N-1:0]                pad_out_o,
   output logic [cnt_width(N)-1:0]     shift_cnt_o
);

   localparam int             CW      = cnt_width(N);
   localparam logic [CW-1:0]  CNT_MAX = CW'(N);

   logic          shift_en;
   logic          capture_en;
   logic          update_en;
   logic [N-1:0]  sr;
   logic [CW-1:0] shift_cnt;

   // Gate the TAP strobes with the instruction select; shift beats capture.
   always_comb begin
      shift_en   = enable_i & shift_dr_i;
      capture_en = enable_i & capture_dr_i & ~shift_dr_i;
      update_en  = enable_i & update_dr_i;
   end

   for (genvar i = 0; i < N; i++) begin : g_cell
      logic cell_scan_in;

      // Serial link: the top cell takes TDI and every other cell takes the
      // bit above it.
      if (i == N - 1) begin : g_top
         always_comb cell_scan_in = scan_in_i;
      end else begin : g_mid
         always_comb cell_scan_in = sr[i+1];
      end

      bs_chain_cell #(
         .CONTROLLABLE (CTRL_MASK[i] == BS_CONTROL),
         .RESET_BIT    (RESET_VAL[i])
      ) u_cell (
         .clk        (clk_i),
         .rst_n      (rst_ni),
         .shift_en   (shift_en),
         .capture_en (capture_en),
         .update_en  (update_en),
         .scan_in    (cell_scan_in),
         .core_in    (core_in_i[i]),
         .mode       (mode_i),
         .sr         (sr[i]),
         .pad_out    (pad_out_o[i])
      );
   end

   // Shift counter: cleared by capture and saturating at N on shifts.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shift_cnt <= '0;
      end else if (shift_en) begin
         if (shift_cnt != CNT_MAX) begin
            shift_cnt <= shift_cnt + 1'b1;
         end
      end else if (capture_en) begin
         shift_cnt <= '0;
      end
   end

   // TDO is taken directly from the register and changes right after the
   // shift edge.
   always_comb begin
      scan_out_o  = sr[0];
      shift_cnt_o = shift_cnt;
   end

endmodule : bs_chain

// File: tb/tb_bs_chain.sv
// Directed bench for bs_chain.
// Two instances share every input. Instance a uses a fully controllable mask
// and instance b uses mask 0x0F. A behavioural model tracks the data
// register, the update register and the shift count. Both instances are
// checked against that model on every falling edge, and literal checks pin
// the model itself.
module tb_bs_chain;

   localparam int          N       = 8;
   localparam logic [7:0]  RST_VAL = 8'hA5;
   localparam logic [7:0]  MASK_A  = 8'hFF;
   localparam logic [7:0]  MASK_B  = 8'h0F;

   logic       clk = 1'b0;
   logic       clk_run = 1'b0;
   logic       rst_n = 1'b1;
   logic       en = 1'b1;
   logic       mode = 1'b1;
   logic       shift = 1'b0;
   logic       capture = 1'b0;
   logic       update = 1'b0;
   logic       sin = 1'b0;
   logic [7:0] core = 8'h00;

   logic       scan_a, scan_b;
   logic [7:0] pad_a, pad_b;
   logic [3:0] cnt_a, cnt_b;

   int n_cmp = 0;
   int n_err = 0;
   logic chk_en = 1'b0;

   // Model state
   logic [7:0] m_sr;
   logic [7:0] m_ur;
   int         m_cnt;

   bs_chain #(.N(N), .CTRL_MASK(MASK_A), .RESET_VAL(RST_VAL)) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .mode_i(mode),
      .shift_dr_i(shift), .capture_dr_i(capture), .update_dr_i(update),
      .scan_in_i(sin), .scan_out_o(scan_a), .core_in_i(core),
      .pad_out_o(pad_a), .shift_cnt_o(cnt_a));

   bs_chain #(.N(N), .CTRL_MASK(MASK_B), .RESET_VAL(RST_VAL)) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .mode_i(mode),
      .shift_dr_i(shift), .capture_dr_i(capture), .update_dr_i(update),
      .scan_in_i(sin), .scan_out_o(scan_b), .core_in_i(core),
      .pad_out_o(pad_b), .shift_cnt_o(cnt_b));

   // Clock: held low until clk_run is set, so reset can be tested clockless.
   always begin
      #5;
      if (clk_run) clk = ~clk;
   end

   // Behavioural model of the register state, with rules applied at the clock edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_sr  = 8'h00;
         m_ur  = RST_VAL;
         m_cnt = 0;
      end else if (en) begin
         if (update) m_ur = m_sr;
         if (shift) begin
            m_sr  = {sin, m_sr[7:1]};
            m_cnt = (m_cnt >= N) ? N : m_cnt + 1;
         end else if (capture) begin
            m_sr  = core;
            m_cnt = 0;
         end
      end
   end

   function automatic logic [7:0] exp_pad(input logic [7:0] mask);
      return mode ? ((mask & m_ur) | (~mask & core)) : core;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare of both instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_pad_a",  32'(pad_a),  32'(exp_pad(MASK_A)));
         check("cyc_pad_b",  32'(pad_b),  32'(exp_pad(MASK_B)));
         check("cyc_scan_a", 32'(scan_a), 32'(m_sr[0]));
         check("cyc_scan_b", 32'(scan_b), 32'(m_sr[0]));
         check("cyc_cnt_a",  32'(cnt_a),  32'(m_cnt));
         check("cyc_cnt_b",  32'(cnt_b),  32'(m_cnt));
      end
   end

   // Driver: called at a falling edge. It applies the strobes, then waits through one rising edge.
   task automatic step(input logic s, input logic c, input logic u, input logic si);
      #1;
      shift = s; capture = c; update = u; sin = si;
      @(negedge clk);
   endtask

   initial begin : main
      logic [7:0] pat;

      // Clockless cold reset
      #5 rst_n = 1'b0;
      #1;
      check("rst_pad_a", 32'(pad_a),  32'h0000_00A5);
      check("rst_pad_b", 32'(pad_b),  32'h0000_0005);
      check("rst_scan",  32'(scan_a), 32'h0);
      check("rst_cnt",   32'(cnt_a),  32'h0);
      clk_run = 1'b1;
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk_en = 1'b1;

      // SAMPLE: capture 0x3C, then shift it out LSB first
      mode = 1'b0;
      core = 8'h3C;
      pat  = 8'h3C;
      step(0, 1, 0, 0);
      check("sample_bit0", 32'(scan_a), 32'(pat[0]));
      for (int k = 1; k < 8; k++) begin
         step(1, 0, 0, 0);
         check("sample_bit", 32'(scan_a), 32'(pat[k]));
      end
      step(1, 0, 0, 0);
      check("sample_cnt8", 32'(cnt_a), 32'd8);
      step(1, 0, 0, 0);
      check("sample_cnt_sat", 32'(cnt_a), 32'd8);

      // PRELOAD 0x96, then EXTEST
      pat = 8'h96;
      for (int i = 0; i < 8; i++) step(1, 0, 0, pat[i]);
      mode = 1'b1;
      step(0, 0, 1, 0);
      check("extest_pad", 32'(pad_a), 32'h96);
      #1 core = 8'h5A; mode = 1'b0;
      #1 check("func_pad", 32'(pad_a), 32'h5A);

      // Observe-only mask: ur = 0xFF, core = 0x00, test mode
      core = 8'h00; mode = 1'b1;
      for (int i = 0; i < 8; i++) step(1, 0, 0, 1);
      step(0, 0, 1, 0);
      check("mask_pad_b", 32'(pad_b), 32'h0F);
      check("mask_pad_a", 32'(pad_a), 32'hFF);

      // Gating: capture 0xC3, then all strobes with enable low
      core = 8'hC3;
      step(0, 1, 0, 0);
      core = 8'h00;
      en = 1'b0;
      for (int i = 0; i < 3; i++) step(1, 1, 1, 1);
      check("gate_cnt",  32'(cnt_a),  32'd0);
      check("gate_scan", 32'(scan_a), 32'd1);
      check("gate_pad",  32'(pad_a),  32'hFF);
      en = 1'b1;

      // Update together with shift: ur takes the pre-shift 0xC3
      step(1, 0, 1, 1);
      check("upd_shift_pad",  32'(pad_a),  32'hC3);
      check("upd_shift_scan", 32'(scan_a), 32'd1);
      check("upd_shift_cnt",  32'(cnt_a),  32'd1);

      // Shift and capture together: shift wins (0xE1 -> 0x70)
      core = 8'hFF;
      step(1, 1, 0, 0);
      check("prio_scan", 32'(scan_a), 32'd0);
      check("prio_cnt",  32'(cnt_a),  32'd2);

      // Reset in the middle of a shift
      step(0, 1, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 1);
      #3 rst_n = 1'b0;
      #1;
      check("midrst_pad",  32'(pad_a),  32'hA5);
      check("midrst_scan", 32'(scan_a), 32'd0);
      check("midrst_cnt",  32'(cnt_a),  32'd0);
      mode = 1'b0; core = 8'h3C;
      #1 check("midrst_func_pad", 32'(pad_a), 32'h3C);
      @(negedge clk);
      #1 rst_n = 1'b1;
      shift = 1'b0; capture = 1'b0; update = 1'b0; sin = 1'b0;
      @(negedge clk);

      // After reset: a fresh capture/shift sequence
      mode = 1'b1;
      step(0, 1, 0, 0);
      check("post_scan0", 32'(scan_a), 32'd0);
      check("post_pad",   32'(pad_a),  32'hA5);
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      check("post_scan2", 32'(scan_a), 32'd1);
      check("post_cnt",   32'(cnt_a),  32'd2);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_bs_chain
